// File: rtl/vdcm_ssm_pkg.sv
// vdcm_ssm_pkg: shared substream constants and request-decode helper.
package vdcm_ssm_pkg;
    localparam int NUM_SSM = 4;
    localparam int MUX_W = 128;
    localparam int KW = $clog2(NUM_SSM) + 1;

    // Number of requesters below substream s, i.e. the queue offset s reads from.
    function automatic logic [KW-1:0] popcount_below(input logic [NUM_SSM-1:0] mask, input int s);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < NUM_SSM; i++)
            if (i < s) k = k + KW'(mask[i]);
        return k;
    endfunction
endpackage

// File: rtl/ssm_word_queue.sv
// ssm_word_queue: circular word store with one write port and NUM_RD read ports at offsets 0..NUM_RD-1.
module ssm_word_queue #(
    parameter int W = 128,
    parameter int DEPTH = 8,
    parameter int NUM_RD = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic                      push,
    input  logic [W-1:0]              wdata,
    input  logic [$clog2(NUM_RD):0]   pop_n,
    output logic [NUM_RD*W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push && !flush) mem_d[wr_ptr_q] = wdata;
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop_n);
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop_n);
        rdata = '0;
        for (int i = 0; i < NUM_RD; i++)
            rdata[i*W +: W] = mem_q[PW'(rd_ptr_q + PW'(i))];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/ssm_demux.sv
// ssm_demux: hands queued mux words to requesting substream parsers in ascending substream order.
module ssm_demux #(
    parameter int NUM_SSM = 4,
    parameter int MUX_W = 128,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       slice_start,
    input  logic                       in_valid,
    input  logic [MUX_W-1:0]           in_data,
    output logic                       in_ready,
    input  logic [NUM_SSM-1:0]         ssm_rd_en,
    output logic [NUM_SSM*MUX_W-1:0]   ssm_data,
    output logic                       req_ok,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       underflow_err
);
    import vdcm_ssm_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [KW-1:0]              npop, pop_n, k;
    logic [NUM_SSM*MUX_W-1:0]   q_rdata;
    logic [CW-1:0]              count;
    logic                       push;
    logic                       underflow_err_q, underflow_err_d;

    ssm_word_queue #(.W(MUX_W), .DEPTH(DEPTH), .NUM_RD(NUM_SSM)) u_queue (
        .clk   (clk),
        .rstn  (rstn),
        .flush (slice_start),
        .push  (push),
        .wdata (in_data),
        .pop_n (pop_n),
        .rdata (q_rdata),
        .count (count)
    );

    always_comb begin
        npop = popcount_below(ssm_rd_en, NUM_SSM);
        req_ok = count >= CW'(npop);
        in_ready = (count < CW'(DEPTH)) && !slice_start;
        push = in_valid && in_ready;
        pop_n = (req_ok && !slice_start) ? npop : '0;
        underflow_err_d = slice_start ? 1'b0 : underflow_err_q || (npop != '0 && !req_ok);
        k = '0;
        ssm_data = '0;
        // An unserved request drives every lane to zero rather than a partial set.
        for (int s = 0; s < NUM_SSM; s++) begin
            k = popcount_below(ssm_rd_en, s);
            if (ssm_rd_en[s] && req_ok) ssm_data[s*MUX_W +: MUX_W] = q_rdata[int'(k)*MUX_W +: MUX_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) underflow_err_q <= 1'b0;
        else underflow_err_q <= underflow_err_d;
    end

    assign occupancy = count;
    assign underflow_err = underflow_err_q;
endmodule

// File: tb/tb_ssm_demux.sv
// tb_ssm_demux: directed stimulus with a scoreboard queue checked by a negedge monitor.
module tb_ssm_demux;
    logic         clk = 0;
    logic         rstn = 0;
    logic         slice_start = 0;
    logic         in_valid = 0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic [3:0]   ssm_rd_en = '0;
    logic [511:0] ssm_data;
    logic         req_ok;
    logic [3:0]   occupancy;
    logic         underflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string        nm;
        logic [511:0] d;
        logic         rok;
        logic [3:0]   occ;
        logic         err;
        logic         rdy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    ssm_demux dut (
        .clk           (clk),
        .rstn          (rstn),
        .slice_start   (slice_start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .ssm_rd_en     (ssm_rd_en),
        .ssm_data      (ssm_data),
        .req_ok        (req_ok),
        .occupancy     (occupancy),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] w(input int i);
        return {16'(i + 1), {7{16'(i) ^ 16'hA5C3}}};
    endfunction

    function automatic logic [511:0] lanes(input logic [127:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic cmp(input string nm, input string f, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h want %0h", nm, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            cmp(mon_e.nm, "ssm_data", ssm_data, mon_e.d);
            cmp(mon_e.nm, "req_ok", 512'(req_ok), 512'(mon_e.rok));
            cmp(mon_e.nm, "occupancy", 512'(occupancy), 512'(mon_e.occ));
            cmp(mon_e.nm, "underflow_err", 512'(underflow_err), 512'(mon_e.err));
            cmp(mon_e.nm, "in_ready", 512'(in_ready), 512'(mon_e.rdy));
        end
    end

    task automatic cyc(input logic v, input logic [127:0] d, input logic [3:0] rd, input logic ss,
                       input string nm, input logic [511:0] ed, input logic erok,
                       input logic [3:0] eocc, input logic eerr, input logic erdy);
        in_valid = v;
        in_data = d;
        ssm_rd_en = rd;
        slice_start = ss;
        sb.push_back('{nm, ed, erok, eocc, eerr, erdy});
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input int i, input logic [3:0] eocc, input logic eerr);
        cyc(1'b1, w(i), 4'b0000, 1'b0, "push", '0, 1'b1, eocc, eerr, 1'b1);
    endtask

    task automatic idle(input string nm, input logic [3:0] eocc, input logic eerr);
        cyc(1'b0, '0, 4'b0000, 1'b0, nm, '0, 1'b1, eocc, eerr, 1'b1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        idle("reset", 4'd0, 1'b0);
        rstn = 1;
        for (int i = 0; i < 4; i++) push_w(i, 4'(i), 1'b0);
        cyc(0, '0, 4'b0001, 0, "pop_lane0", lanes(w(0), '0, '0, '0), 1, 4'd4, 0, 1);
        cyc(0, '0, 4'b0100, 0, "pop_lane2", lanes('0, '0, w(1), '0), 1, 4'd3, 0, 1);
        idle("occ_after_pops", 4'd2, 1'b0);
        cyc(0, '0, 4'b0011, 0, "drain", lanes(w(2), w(3), '0, '0), 1, 4'd2, 0, 1);
        for (int i = 4; i < 10; i++) push_w(i, 4'(i - 4), 1'b0);
        cyc(0, '0, 4'b1011, 0, "multi_pop", lanes(w(4), w(5), '0, w(6)), 1, 4'd6, 0, 1);
        cyc(0, '0, 4'b0111, 0, "multi_rest", lanes(w(7), w(8), w(9), '0), 1, 4'd3, 0, 1);
        for (int i = 10; i < 14; i++) push_w(i, 4'(i - 10), 1'b0);
        cyc(0, '0, 4'b1111, 0, "advance", lanes(w(10), w(11), w(12), w(13)), 1, 4'd4, 0, 1);
        for (int i = 14; i < 19; i++) push_w(i, 4'(i - 14), 1'b0);
        cyc(0, '0, 4'b1111, 0, "wrap", lanes(w(14), w(15), w(16), w(17)), 1, 4'd5, 0, 1);
        push_w(19, 4'd1, 1'b0);
        cyc(0, '0, 4'b0111, 0, "underflow", '0, 0, 4'd2, 0, 1);
        idle("sticky", 4'd2, 1'b1);
        cyc(0, '0, 4'b0001, 0, "after_under", lanes(w(18), '0, '0, '0), 1, 4'd2, 1, 1);
        cyc(0, '0, 4'b0001, 0, "after_under2", lanes(w(19), '0, '0, '0), 1, 4'd1, 1, 1);
        for (int i = 20; i < 28; i++) push_w(i, 4'(i - 20), 1'b1);
        cyc(1, w(28), 4'b0001, 0, "full_push_pop", lanes(w(20), '0, '0, '0), 1, 4'd8, 1, 0);
        idle("full_next", 4'd7, 1'b1);
        cyc(0, '0, 4'b0001, 0, "full_pop1", lanes(w(21), '0, '0, '0), 1, 4'd7, 1, 1);
        cyc(0, '0, 4'b1111, 0, "full_pop4", lanes(w(22), w(23), w(24), w(25)), 1, 4'd6, 1, 1);
        cyc(0, '0, 4'b0011, 0, "full_pop2", lanes(w(26), w(27), '0, '0), 1, 4'd2, 1, 1);
        idle("refused_dropped", 4'd0, 1'b1);
        for (int i = 30; i < 35; i++) push_w(i, 4'(i - 30), 1'b1);
        cyc(1, w(35), 4'b0000, 1, "flush_pulse", '0, 1, 4'd5, 1, 0);
        idle("flushed", 4'd0, 1'b0);
        push_w(36, 4'd0, 1'b0);
        cyc(0, '0, 4'b0001, 0, "post_flush_pop", lanes(w(36), '0, '0, '0), 1, 4'd1, 0, 1);
        push_w(40, 4'd0, 1'b0);
        push_w(41, 4'd1, 1'b0);
        cyc(0, '0, 4'b0111, 0, "underflow2", '0, 0, 4'd2, 0, 1);
        rstn = 0;
        idle("async_reset", 4'd0, 1'b0);
        rstn = 1;
        idle("after_reset", 4'd0, 1'b0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
